// File: rtl/cart2pol_pkg.sv
// Shared constants for the CORDIC Cartesian-to-polar converter: datapath
// widths, the arctangent table, the inverse CORDIC gain and stage helpers.
package cart2pol_pkg;

  localparam int IN_W  = 8;   // input coordinate width
  localparam int OUT_W = 8;   // r1 / theta1 width
  localparam int EXT_W = 2;   // integer headroom for CORDIC gain and |-128| negation

  // atan(2^-i) in binary-angle units (128 = pi), held at 16 fractional bits
  // and reduced to the datapath guard width by atan_const().
  localparam int ATAN_FRAC = 16;
  localparam int ATAN_TBL [0:13] = '{
    2097152, 1238021, 654136, 332050, 166669, 83416, 41718,
    20860,   10430,   5215,   2608,   1304,   652,   326
  };

  // 1/K of the converged CORDIC gain, unsigned with 16 fractional bits.
  localparam int INV_GAIN_FRAC = 16;
  localparam int INV_GAIN_W    = 16;
  localparam logic [INV_GAIN_W-1:0] INV_GAIN = 16'd39797;

  // Micro-rotation stage k (1..ITER) shifts by k-1.
  function automatic int stage_shift(input int stage);
    return stage - 1;
  endfunction

  function automatic int atan_const(input int shift, input int guard);
    return (ATAN_TBL[shift] + (1 << (ATAN_FRAC - guard - 1))) >>> (ATAN_FRAC - guard);
  endfunction

  // Half-LSB bias so a right shift rounds to nearest instead of flooring.
  function automatic int round_bias(input int shift);
    return (shift > 0) ? (1 << (shift - 1)) : 0;
  endfunction

endpackage

// File: rtl/cartesian_to_polar_if.sv
// Sample/result bus of the Cartesian-to-polar converter.
// CART2POL_ZERO_EN adds the 'zero' result flag.
interface cartesian_to_polar_if;
  import cart2pol_pkg::*;

  logic                    in_valid;
  logic signed [IN_W-1:0]  x;
  logic signed [IN_W-1:0]  y;
  logic                    out_valid;
  logic [OUT_W-1:0]        r1;
  logic signed [OUT_W-1:0] theta1;

`ifdef CART2POL_ZERO_EN
  logic                    zero;

  modport master (output in_valid, x, y, input out_valid, r1, theta1, zero);
  modport slave  (input in_valid, x, y, output out_valid, r1, theta1, zero);
`else
  modport master (output in_valid, x, y, input out_valid, r1, theta1);
  modport slave  (input in_valid, x, y, output out_valid, r1, theta1);
`endif

endinterface

// File: rtl/cart2pol_cordic_stage.sv
// One registered CORDIC vectoring micro-rotation. Shifted terms are rounded
// to nearest, which keeps small-magnitude inputs inside the angle tolerance.
module cart2pol_cordic_stage
  import cart2pol_pkg::*;
#(
  parameter int STAGE = 1,
  parameter int DW    = 16,
  parameter int GUARD = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [DW-1:0] z_in,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] y_out,
  output logic signed [DW-1:0] z_out
);

  localparam int SH = stage_shift(STAGE);
  localparam logic signed [DW-1:0] RND  = DW'(round_bias(SH));
  localparam logic signed [DW-1:0] ATAN = DW'(atan_const(SH, GUARD));

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;

  assign x_sh = (x_in + RND) >>> SH;
  assign y_sh = (y_in + RND) >>> SH;

  // Rotate toward the +x axis: y >= 0 rotates clockwise, y < 0 counter-clockwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (!y_in[DW-1]) begin
      x_out <= x_in + y_sh;
      y_out <= y_in - x_sh;
      z_out <= z_in + ATAN;
    end else begin
      x_out <= x_in - y_sh;
      y_out <= y_in + x_sh;
      z_out <= z_in - ATAN;
    end
  end

endmodule

// File: rtl/cartesian_to_polar.sv
// Pipelined CORDIC vectoring converter, signed 8-bit (x,y) -> (r1,theta1).
// theta1 is a binary angle (128 = pi). Latency ITER+2, one sample per clock.
// CART2POL_ZERO_EN adds a 'zero' flag marking results of an (0,0) input.
module cartesian_to_polar
  import cart2pol_pkg::*;
#(
  parameter int ITER  = 10,
  parameter int GUARD = 6
) (
  input logic            clk,
  input logic            rst,
  cartesian_to_polar_if.slave bus
);

  localparam int DW  = IN_W + GUARD + EXT_W;
  localparam int PW  = DW + INV_GAIN_W;
  localparam int RSH = GUARD + INV_GAIN_FRAC;

  localparam logic signed [DW-1:0] Z_PI   = DW'(128 << GUARD);
  localparam logic signed [DW-1:0] Z_HALF = DW'(round_bias(GUARD));
  localparam logic [PW-1:0]        R_HALF = PW'(1) << (RSH - 1);

  logic signed [DW-1:0] x_ext;
  logic signed [DW-1:0] y_ext;
  logic                 in_zero;

  logic signed [DW-1:0] x0;
  logic signed [DW-1:0] y0;
  logic signed [DW-1:0] z0;

  logic signed [DW-1:0] xs [1:ITER];
  logic signed [DW-1:0] ys [1:ITER];
  logic signed [DW-1:0] zs [1:ITER];

  logic [ITER:0] vld_sr;
  logic [ITER:0] zero_sr;
  logic [PW-1:0] r_prod;

  assign x_ext   = DW'(bus.x) <<< GUARD;
  assign y_ext   = DW'(bus.y) <<< GUARD;
  assign in_zero = (bus.x == '0) && (bus.y == '0);

  // Fold the left half-plane onto the right half by a pi rotation and seed z with +-pi.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else if (bus.x[IN_W-1]) begin
      x0 <= -x_ext;
      y0 <= -y_ext;
      z0 <= bus.y[IN_W-1] ? -Z_PI : Z_PI;
    end else begin
      x0 <= x_ext;
      y0 <= y_ext;
      z0 <= '0;
    end
  end

  for (genvar k = 1; k <= ITER; k++) begin : g_stage
    logic signed [DW-1:0] xi;
    logic signed [DW-1:0] yi;
    logic signed [DW-1:0] zi;

    if (k == 1) begin : g_first
      assign xi = x0;
      assign yi = y0;
      assign zi = z0;
    end else begin : g_chain
      assign xi = xs[k-1];
      assign yi = ys[k-1];
      assign zi = zs[k-1];
    end

    cart2pol_cordic_stage #(
      .STAGE (k),
      .DW    (DW),
      .GUARD (GUARD)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .x_in  (xi),
      .y_in  (yi),
      .z_in  (zi),
      .x_out (xs[k]),
      .y_out (ys[k]),
      .z_out (zs[k])
    );
  end

  // Valid and zero-input flags travel alongside the data through stage 0..ITER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      zero_sr <= '0;
    end else begin
      vld_sr  <= {vld_sr[ITER-1:0], bus.in_valid};
      zero_sr <= {zero_sr[ITER-1:0], in_zero};
    end
  end

  // x is never negative after the pre-rotation, so the gain correction is unsigned.
  assign r_prod = PW'($unsigned(xs[ITER])) * PW'(INV_GAIN);

  // Output register: remove CORDIC gain, round both results, hold when idle.
  // A zero input never converges in z, so its angle is forced to 0 here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.r1        <= '0;
      bus.theta1    <= '0;
`ifdef CART2POL_ZERO_EN
      bus.zero      <= 1'b0;
`endif
    end else begin
      bus.out_valid <= vld_sr[ITER];
      if (vld_sr[ITER]) begin
        bus.r1     <= OUT_W'((r_prod + R_HALF) >> RSH);
        bus.theta1 <= zero_sr[ITER] ? '0 : OUT_W'((zs[ITER] + Z_HALF) >>> GUARD);
`ifdef CART2POL_ZERO_EN
        bus.zero   <= zero_sr[ITER];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cartesian_to_polar.sv
// Directed and model-based bench for cartesian_to_polar.
module tb_cartesian_to_polar;

  localparam int ITER = 10;
  localparam int LAT  = ITER + 2;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cartesian_to_polar_if bus ();

  cartesian_to_polar #(
    .ITER  (ITER),
    .GUARD (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int sx[$];
  int sy[$];
  int er[$];
  int et[$];
  bit rex[$];
  bit tex[$];
  bit use_model;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input real exp, input bit modular);
    real d;
    bit  ok;
    d = real'(obs) - exp;
    if (modular) d = d - 256.0 * $floor((d + 128.0) / 256.0);
    ok = (d <= 1.0) && (d >= -1.0);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.3f (+-1)", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input int x, input int y, input int r, input int t,
                         input bit r_exact, input bit t_exact);
    sx.push_back(x);
    sy.push_back(y);
    er.push_back(r);
    et.push_back(t);
    rex.push_back(r_exact);
    tex.push_back(t_exact);
  endtask

  task automatic clear_vecs();
    sx.delete(); sy.delete(); er.delete(); et.delete(); rex.delete(); tex.delete();
  endtask

  task automatic check_result(input int j);
    int    xi;
    int    yi;
    int    r_obs;
    int    t_obs;
    real   r_ref;
    real   t_ref;
    string id;
    xi    = sx[j];
    yi    = sy[j];
    r_obs = int'(bus.r1);
    t_obs = int'(bus.theta1);
    id    = $sformatf("[%0d](%0d,%0d)", j, xi, yi);
    if (use_model) begin
      if (xi == 0 && yi == 0) begin
        check_int({"r1_zero", id}, r_obs, 0);
        check_int({"theta1_zero", id}, t_obs, 0);
      end else begin
        r_ref = $sqrt(real'(xi * xi + yi * yi));
        t_ref = $atan2(real'(yi), real'(xi)) * 128.0 / PI;
        check_tol({"r1", id}, r_obs, r_ref, 1'b0);
        check_tol({"theta1", id}, t_obs, t_ref, 1'b1);
      end
    end else begin
      if (rex[j]) check_int({"r1", id}, r_obs, er[j]);
      else        check_tol({"r1", id}, r_obs, real'(er[j]), 1'b0);
      if (tex[j]) check_int({"theta1", id}, t_obs, et[j]);
      else        check_tol({"theta1", id}, t_obs, real'(et[j]), 1'b1);
    end
`ifdef CART2POL_ZERO_EN
    check_int({"zero", id}, int'(bus.zero), int'(xi == 0 && yi == 0));
`endif
  endtask

  // Drive the queued vectors back to back; every cycle the output valid must
  // match the input valid delayed by exactly LAT cycles.
  task automatic run_stream();
    int n;
    int j;
    int exp_v;
    n = sx.size();
    for (int c = 0; c < n + LAT; c++) begin
      @(negedge clk);
      if (c < n) begin
        bus.in_valid = 1'b1;
        bus.x        = 8'(sx[c]);
        bus.y        = 8'(sy[c]);
      end else begin
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
      end
      @(posedge clk);
      #1;
      j     = c - (LAT - 1);
      exp_v = (j >= 0 && j < n) ? 1 : 0;
      check_int($sformatf("out_valid@%0d", c), int'(bus.out_valid), exp_v);
      if (exp_v == 1 && bus.out_valid === 1'b1) check_result(j);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_int({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check_int({tag, "_r1"}, int'(bus.r1), 0);
    check_int({tag, "_theta1"}, int'(bus.theta1), 0);
`ifdef CART2POL_ZERO_EN
    check_int({tag, "_zero"}, int'(bus.zero), 0);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    use_model    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results
    clear_vecs();
    add_vec(   0,    0,   0,    0, 1'b1, 1'b1);
    add_vec(   3,    4,   5,   38, 1'b0, 1'b0);
    add_vec(   6,    8,  10,   38, 1'b0, 1'b0);
    add_vec(   1,    1,   1,   32, 1'b0, 1'b0);
    add_vec(  -3,    4,   5,   90, 1'b0, 1'b0);
    add_vec(   1,   -1,   1,  -32, 1'b0, 1'b0);
    add_vec( -12,   -5,  13, -112, 1'b0, 1'b0);
    add_vec( 123,  -45, 131,  -14, 1'b0, 1'b0);
    add_vec(-128,    0, 128, -128, 1'b0, 1'b0);
    add_vec(   0,  127, 127,   64, 1'b1, 1'b1);
    add_vec(-128, -128, 181,  -96, 1'b0, 1'b0);
    add_vec(   0,  -50,  50,  -64, 1'b0, 1'b1);
    add_vec(  50,    0,  50,    0, 1'b0, 1'b1);
    add_vec(   0, -128, 128,  -64, 1'b0, 1'b1);
    run_stream();

    // Reset with three samples in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 8'sd3;
    bus.y        = 8'sd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_tol("pre_reset_r1", int'(bus.r1), 5.0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = 8'(20 + i);
      bus.y        = 8'(-7 - i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    rst          = 1'b1;
    #1;
    check_outputs_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs_zero($sformatf("rst_hold%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(posedge clk);
      #1;
      check_outputs_zero($sformatf("post_rst%0d", i));
    end

    // Back-to-back random stream against the real-valued model
    use_model = 1'b1;
    clear_vecs();
    for (int i = 0; i < 20; i++)
      add_vec(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              0, 0, 1'b0, 1'b0);
    run_stream();

    // Exhaustive sweep of every (x,y) pair
    clear_vecs();
    for (int xi = -128; xi < 128; xi++)
      for (int yi = -128; yi < 128; yi++)
        add_vec(xi, yi, 0, 0, 1'b0, 1'b0);
    run_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
